// File: rtl/rf_mp.sv
// ---------------------------------------------------------------------------
// rf_mp -- multi-read-port register file with a halt-triggered dump sequence.
//
// Register 0 always reads as zero and ignores writes. Each read port has
// one cycle of latency and holds its value while its enable is low. When
// hlt is asserted in IDLE, the block enters DUMP and streams every register
// (index 0..DEPTH-1) on the dump_* outputs, one per cycle. It then sits in
// DONE with dump_done high until hlt drops. Writes are ignored outside IDLE.
//
// Optional feature macro: RF_BYPASS_EN
//   defined   : a read of address A in the same cycle as an accepted write
//               to A returns the write data.
//   undefined : that read returns the contents of A before the write.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   re         in   [NUM_RD]         per-port read enable
//   rd_addr    in   [NUM_RD*ADDR_W]  packed read addresses
//   rd_data    out  [NUM_RD*DATA_W]  packed registered read data
//   we         in   write enable
//   wr_addr    in   [ADDR_W]         write address
//   wr_data    in   [DATA_W]         write data
//   hlt        in   halt request, starts the dump
//   dump_vld   out  dump_addr/dump_data valid
//   dump_addr  out  [ADDR_W]         register index being dumped
//   dump_data  out  [DATA_W]         contents of that register
//   dump_done  out  dump complete, held until hlt deasserts
// ---------------------------------------------------------------------------
module rf_mp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD-1:0]          re,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       hlt,
    output logic                       dump_vld,
    output logic [ADDR_W-1:0]          dump_addr,
    output logic [DATA_W-1:0]          dump_data,
    output logic                       dump_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DUMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_r, state_nxt_s;
    logic [ADDR_W-1:0]         idx_r, idx_nxt_s;
    logic                      dump_vld_r, dump_vld_nxt_s;
    logic [ADDR_W-1:0]         dump_addr_r, dump_addr_nxt_s;
    logic [DATA_W-1:0]         dump_data_r, dump_data_nxt_s;
    logic                      dump_done_r, dump_done_nxt_s;
    logic [DATA_W-1:0]         mem_r [DEPTH];
    logic                      wr_acc_s;
    logic [NUM_RD*DATA_W-1:0]  rd_sel_s;
    logic [NUM_RD*DATA_W-1:0]  rd_data_r;

    // A write lands only in IDLE and never to the hard-wired zero register.
    assign wr_acc_s = we && (wr_addr != {ADDR_W{1'b0}}) && (state_r == ST_IDLE);

    // Per-port read selection: zero register, optional write bypass, or array.
    always_comb begin
        rd_sel_s = {(NUM_RD*DATA_W){1'b0}};
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_addr[i*ADDR_W +: ADDR_W] == {ADDR_W{1'b0}}) begin
                rd_sel_s[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end
`ifdef RF_BYPASS_EN
            else if (wr_acc_s && (wr_addr == rd_addr[i*ADDR_W +: ADDR_W])) begin
                rd_sel_s[i*DATA_W +: DATA_W] = wr_data;
            end
`endif
            else begin
                rd_sel_s[i*DATA_W +: DATA_W] = mem_r[rd_addr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    // Read data registers; a disabled port keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= {(NUM_RD*DATA_W){1'b0}};
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (re[i]) begin
                    rd_data_r[i*DATA_W +: DATA_W] <= rd_sel_s[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Register array storage; entry 0 is never written so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_r[j] <= {DATA_W{1'b0}};
            end
        end else if (wr_acc_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Dump sequencer next state and next values of the registered dump outputs.
    // The outputs are computed one step ahead so that while the state register
    // says DUMP at index k, the dump_* flops already present register k.
    always_comb begin
        state_nxt_s     = state_r;
        idx_nxt_s       = idx_r;
        dump_vld_nxt_s  = 1'b0;
        dump_addr_nxt_s = {ADDR_W{1'b0}};
        dump_data_nxt_s = {DATA_W{1'b0}};
        dump_done_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                idx_nxt_s = {ADDR_W{1'b0}};
                if (hlt) begin
                    state_nxt_s    = ST_DUMP;
                    dump_vld_nxt_s = 1'b1;   // index 0 shows as zero
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_DUMP: begin
                if (idx_r == LAST_IDX) begin
                    state_nxt_s     = ST_DONE;
                    dump_done_nxt_s = 1'b1;
                end else begin
                    idx_nxt_s       = idx_r + ADDR_W'(1);
                    dump_vld_nxt_s  = 1'b1;
                    dump_addr_nxt_s = idx_r + ADDR_W'(1);
                    dump_data_nxt_s = mem_r[idx_r + ADDR_W'(1)];
                end
            end
            ST_DONE: begin
                if (hlt) begin
                    dump_done_nxt_s = 1'b1;
                end else begin
                    state_nxt_s     = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Dump sequencer state and registered dump outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= {ADDR_W{1'b0}};
            dump_vld_r  <= 1'b0;
            dump_addr_r <= {ADDR_W{1'b0}};
            dump_data_r <= {DATA_W{1'b0}};
            dump_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            dump_vld_r  <= dump_vld_nxt_s;
            dump_addr_r <= dump_addr_nxt_s;
            dump_data_r <= dump_data_nxt_s;
            dump_done_r <= dump_done_nxt_s;
        end
    end

    assign rd_data   = rd_data_r;
    assign dump_vld  = dump_vld_r;
    assign dump_addr = dump_addr_r;
    assign dump_data = dump_data_r;
    assign dump_done = dump_done_r;

endmodule

// File: doc/rf_mp.md
RF_MP -- requirements
Module: rf_mp

Interface
REQ-001 Parameter DATA_W, default 16, register width in bits.
REQ-002 Parameter ADDR_W, default 4, register address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, default 2, number of read ports (1..8).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 re  input  NUM_RD  per-port read enable; bit i controls port i.
REQ-007 rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-008 rd_data  output  NUM_RD*DATA_W  packed registered read data; port i at bits [i*DATA_W +: DATA_W].
REQ-009 we  input  1  write enable.
REQ-010 wr_addr  input  ADDR_W  write address.
REQ-011 wr_data  input  DATA_W  write data.
REQ-012 hlt  input  1  halt request; starts the register dump sequence.
REQ-013 dump_vld  output  1  dump_addr/dump_data valid this cycle.
REQ-014 dump_addr  output  ADDR_W  register index being dumped.
REQ-015 dump_data  output  DATA_W  contents of register dump_addr.
REQ-016 dump_done  output  1  dump complete; held until hlt deasserts.

Function
REQ-017 Register 0 SHALL always read as zero; writes to address 0 SHALL be discarded.
REQ-018 Write: when we=1, wr_addr!=0 and FSM in IDLE, mem[wr_addr] SHALL take wr_data at the rising edge.
REQ-019 Read latency 1 cycle: when re[i]=1, rd_data port i SHALL load the value selected at the rising edge; when re[i]=0, port i SHALL hold its previous value.
REQ-020 All NUM_RD ports SHALL be independent; any ports may address the same register in the same cycle.
REQ-021 Same-cycle write/read of the same nonzero address: result per REQ-033/REQ-034.
REQ-022 FSM states: IDLE, DUMP, DONE.
REQ-023 IDLE -> DUMP when hlt=1; dump index cleared to 0.
REQ-024 DUMP: each cycle dump_vld=1, dump_addr=index, dump_data=mem[index] (zero for index 0); index increments by 1.
REQ-025 DUMP -> DONE after the cycle with index DEPTH-1; exactly DEPTH dump_vld cycles, no wrap.
REQ-026 DONE: dump_vld=0, dump_done=1; DONE -> IDLE when hlt=0.
REQ-027 hlt deasserted during DUMP SHALL NOT abort; dump completes, then DONE -> IDLE the following cycle.
REQ-028 Writes SHALL be ignored in DUMP and DONE; reads SHALL continue to operate normally.
REQ-029 dump_vld, dump_addr, dump_data, dump_done SHALL be registered outputs.

Reset
REQ-030 While rst=1, all DEPTH registers SHALL be 0, rd_data all 0, FSM IDLE, index 0, dump_vld=0, dump_addr=0, dump_data=0, dump_done=0.
REQ-031 rst asserted mid-dump SHALL abort immediately to IDLE with outputs per REQ-030.
REQ-032 First write accepted at first rising edge after rst deasserts.

Configuration
REQ-033 With macro RF_BYPASS_EN defined: a read of address A!=0 in the same cycle as an accepted write to A SHALL return wr_data.
REQ-034 Without RF_BYPASS_EN: that read SHALL return the pre-write contents of A; the new value is visible from the next read.

Verification
REQ-035 Reset, then re=all 1s, rd_addr all 5 -> rd_data all 0 next cycle.
REQ-036 Write 0xBEEF to r3, next cycle read r3 on port 0 and r0 on port 1 -> port0=0xBEEF, port1=0x0000; write 0x1234 to r0 -> r0 still reads 0.
REQ-037 Write 0xA5A5 to r7 while port 1 reads r7 -> 0xA5A5 with RF_BYPASS_EN, old value 0x0000 without.
REQ-038 Load r1..r15 with 0x1000+i, pulse hlt for 1 cycle -> 16 consecutive dump_vld cycles, addr 0..15, data 0,0x1001..0x100F, then dump_done=1 for one cycle, then IDLE.
REQ-039 Hold hlt=1 through dump, issue we to r2 with 0xFFFF during DUMP -> r2 unchanged in dump and later reads; dump_done held until hlt=0.
REQ-040 Assert rst at dump index 6 -> dump_vld=0 immediately, all registers read 0 after release.
